// File: rtl/an_sec_decoder_seq.sv
// Sequential single-error-correcting AN-code decoder: bit-serial division,
// iterative +/-2^k residue search, correction and re-division.
module an_sec_decoder_seq #(
    parameter int A       = 131,
    parameter int A_BITS  = 8,
    parameter int W_BITS  = 61,
    parameter int N_BITS  = 53,
    parameter int LOC_MAX = 60,
    parameter int L_BITS  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_BITS-1:0] W,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] N,
    output logic              err_det,
    output logic              err_corr,
    output logic              err_uncorr,
    output logic              err_sign,
    output logic [L_BITS-1:0] err_loc,
    output logic              n_ovf
);

    localparam int C_BITS = $clog2(W_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_DIV1, S_EVAL, S_SEARCH, S_CORR, S_DIV2, S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [W_BITS-1:0] r_w;
    logic [W_BITS-1:0] r_sh;
    logic [A_BITS-1:0] r_rem;
    logic [C_BITS-1:0] r_cnt;
    logic [L_BITS-1:0] r_k;
    logic [A_BITS-1:0] r_p;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [N_BITS-1:0] r_n;
    logic              r_err_det;
    logic              r_err_corr;
    logic              r_err_uncorr;
    logic              r_err_sign;
    logic [L_BITS-1:0] r_err_loc;
    logic              r_n_ovf;

    // r_sh holds the dividend bits still to consume; quotient bits enter at the LSB
    logic [A_BITS:0]   w_trial;
    logic              w_qbit;
    logic [A_BITS-1:0] w_rem_nxt;
    logic [W_BITS-1:0] w_sh_nxt;
    logic              w_div_last;
    logic              w_match_pos;
    logic              w_match_neg;
    logic              w_k_last;
    logic [A_BITS:0]   w_p2;
    logic [A_BITS-1:0] w_p_nxt;
    logic [W_BITS:0]   w_pow;
    logic [W_BITS:0]   w_corr;
    logic              w_range_fail;

    function automatic logic q_ovf(input logic [W_BITS-1:0] q);
        return |q[W_BITS-1:N_BITS];
    endfunction

    assign w_trial      = {r_rem, r_sh[W_BITS-1]};
    assign w_qbit       = (w_trial >= (A_BITS+1)'(A));
    assign w_rem_nxt    = w_qbit ? A_BITS'(w_trial - (A_BITS+1)'(A)) : w_trial[A_BITS-1:0];
    assign w_sh_nxt     = {r_sh[W_BITS-2:0], w_qbit};
    assign w_div_last   = (r_cnt == C_BITS'(0));
    assign w_match_pos  = (r_rem == r_p);
    assign w_match_neg  = (r_rem == (A_BITS'(A) - r_p));
    assign w_k_last     = (r_k == L_BITS'(LOC_MAX));
    assign w_p2         = {r_p, 1'b0};
    assign w_p_nxt      = (w_p2 >= (A_BITS+1)'(A)) ? A_BITS'(w_p2 - (A_BITS+1)'(A)) : w_p2[A_BITS-1:0];
    assign w_pow        = (W_BITS+1)'(1) << r_k;
    // Bit W_BITS catches both a borrow below zero and a carry out of the codeword
    assign w_corr       = r_err_sign ? ({1'b0, r_w} - w_pow) : ({1'b0, r_w} + w_pow);
    assign w_range_fail = w_corr[W_BITS];

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid) w_next = S_DIV1; else w_next = S_IDLE;
            S_DIV1:   if (w_div_last) w_next = S_EVAL; else w_next = S_DIV1;
            S_EVAL:   if (r_rem == A_BITS'(0)) w_next = S_DONE; else w_next = S_SEARCH;
            S_SEARCH: if (w_match_pos || w_match_neg) w_next = S_CORR;
                      else if (w_k_last) w_next = S_DONE;
                      else w_next = S_SEARCH;
            S_CORR:   if (w_range_fail) w_next = S_DONE; else w_next = S_DIV2;
            S_DIV2:   if (w_div_last) w_next = S_DONE; else w_next = S_DIV2;
            S_DONE:   if (out_ready) w_next = S_IDLE; else w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == S_IDLE);
            r_out_valid <= (w_next == S_DONE);
        end
    end

    // Datapath: division, residue search, correction and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w <= '0; r_sh <= '0; r_rem <= '0; r_cnt <= '0; r_k <= '0; r_p <= '0;
            r_n <= '0; r_err_det <= 1'b0; r_err_corr <= 1'b0; r_err_uncorr <= 1'b0;
            r_err_sign <= 1'b0; r_err_loc <= '0; r_n_ovf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_w <= W; r_sh <= W; r_rem <= '0; r_cnt <= C_BITS'(W_BITS-1);
                        r_n <= '0; r_err_det <= 1'b0; r_err_corr <= 1'b0; r_err_uncorr <= 1'b0;
                        r_err_sign <= 1'b0; r_err_loc <= '0; r_n_ovf <= 1'b0;
                    end
                end
                S_DIV1: begin
                    r_sh <= w_sh_nxt; r_rem <= w_rem_nxt; r_cnt <= r_cnt - C_BITS'(1);
                end
                S_EVAL: begin
                    if (r_rem == A_BITS'(0)) begin
                        r_n <= r_sh[N_BITS-1:0]; r_n_ovf <= q_ovf(r_sh);
                    end else begin
                        r_err_det <= 1'b1; r_k <= '0; r_p <= A_BITS'(1);
                    end
                end
                S_SEARCH: begin
                    if (w_match_pos) begin
                        r_err_sign <= 1'b1; r_err_loc <= r_k;
                    end else if (w_match_neg) begin
                        r_err_sign <= 1'b0; r_err_loc <= r_k;
                    end else if (w_k_last) begin
                        r_err_uncorr <= 1'b1; r_n <= r_sh[N_BITS-1:0]; r_n_ovf <= q_ovf(r_sh);
                    end else begin
                        r_k <= r_k + L_BITS'(1); r_p <= w_p_nxt;
                    end
                end
                S_CORR: begin
                    if (w_range_fail) begin
                        r_err_uncorr <= 1'b1; r_n <= r_sh[N_BITS-1:0]; r_n_ovf <= q_ovf(r_sh);
                    end else begin
                        r_sh <= w_corr[W_BITS-1:0]; r_rem <= '0; r_cnt <= C_BITS'(W_BITS-1);
                    end
                end
                S_DIV2: begin
                    r_sh <= w_sh_nxt; r_rem <= w_rem_nxt; r_cnt <= r_cnt - C_BITS'(1);
                    if (w_div_last) begin
                        r_err_corr <= 1'b1; r_n <= w_sh_nxt[N_BITS-1:0]; r_n_ovf <= q_ovf(w_sh_nxt);
                    end
                end
                S_DONE: begin
                    r_n <= r_n;
                end
                default: begin
                    r_n <= r_n;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign N          = r_n;
    assign err_det    = r_err_det;
    assign err_corr   = r_err_corr;
    assign err_uncorr = r_err_uncorr;
    assign err_sign   = r_err_sign;
    assign err_loc    = r_err_loc;
    assign n_ovf      = r_n_ovf;

endmodule

// File: tb/tb_an_sec_decoder_seq.sv
// Self-checking bench for an_sec_decoder_seq: directed and random codewords
// compared against an arithmetic reference model of the decoding rules.
module tb_an_sec_decoder_seq;

    localparam int          W_BITS  = 61;
    localparam int          N_BITS  = 53;
    localparam int          LOC_MAX = 60;
    localparam logic [63:0] A64     = 64'd131;
    localparam logic [63:0] NMASK   = (64'd1 << N_BITS) - 64'd1;
    localparam logic [63:0] WLIM    = 64'd1 << W_BITS;

    typedef struct packed {
        logic [63:0] n;
        logic        det;
        logic        corr;
        logic        uncorr;
        logic        sign;
        logic [5:0]  loc;
        logic        ovf;
        logic [31:0] lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [60:0] W = '0;
    logic        in_ready, out_valid, err_det, err_corr, err_uncorr, err_sign, n_ovf;
    logic [52:0] N;
    logic [5:0]  err_loc;

    int n_vec = 0;
    int n_err = 0;
    int n_cmp = 0;

    an_sec_decoder_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .W(W),
        .out_valid(out_valid), .out_ready(out_ready), .N(N), .err_det(err_det),
        .err_corr(err_corr), .err_uncorr(err_uncorr), .err_sign(err_sign),
        .err_loc(err_loc), .n_ovf(n_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [60:0] rand61();
        logic [63:0] t;
        t = {32'($urandom), 32'($urandom)};
        return t[60:0];
    endfunction

    // Reference: plain integer division and direct powers of two.
    function automatic exp_t model(input logic [63:0] w);
        exp_t        e;
        logic [63:0] r, two_k, pm, wc;
        logic        found, fail;
        e = '0;
        r = w % A64;
        e.n = w / A64;
        e.lat = 32'(W_BITS + 2);
        if (r != 64'd0) begin
            e.det = 1'b1;
            e.uncorr = 1'b1;
            e.lat = 32'(W_BITS + LOC_MAX + 3);
            found = 1'b0;
            for (int k = 0; k <= LOC_MAX; k++) begin
                two_k = 64'd1 << k;
                pm = two_k % A64;
                if (!found && (r == pm || r == A64 - pm)) begin
                    found = 1'b1;
                    e.sign = (r == pm);
                    e.loc = 6'(k);
                    if (e.sign) begin
                        fail = (w < two_k);
                        wc = w - two_k;
                    end else begin
                        wc = w + two_k;
                        fail = (wc >= WLIM);
                    end
                    if (fail) begin
                        e.lat = 32'(W_BITS + k + 4);
                    end else begin
                        e.uncorr = 1'b0;
                        e.corr = 1'b1;
                        e.n = wc / A64;
                        e.lat = 32'(2 * W_BITS + k + 4);
                    end
                end
            end
        end
        e.ovf = ((e.n >> N_BITS) != 64'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_result(input exp_t e);
        chk("N", 64'(N), e.n & NMASK);
        chk("err_det", 64'(err_det), 64'(e.det));
        chk("err_corr", 64'(err_corr), 64'(e.corr));
        chk("err_uncorr", 64'(err_uncorr), 64'(e.uncorr));
        chk("err_sign", 64'(err_sign), 64'(e.sign));
        chk("err_loc", 64'(err_loc), 64'(e.loc));
        chk("n_ovf", 64'(n_ovf), 64'(e.ovf));
    endtask

    task automatic chk_idle_zero();
        chk("in_ready_rst", 64'(in_ready), 64'd1);
        chk("out_valid_rst", 64'(out_valid), 64'd0);
        chk("outputs_rst", {N, err_det, err_corr, err_uncorr, err_sign, err_loc, n_ovf}, 64'd0);
    endtask

    // Called at a negedge while idle; returns at the negedge of cycle 1.
    task automatic start(input logic [60:0] w);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        W = w;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        W = rand61();
        n_vec++;
        chk("in_ready_busy", 64'(in_ready), 64'd0);
    endtask

    task automatic finish(input exp_t e, input int hold);
        int cnt;
        cnt = 1;
        while (!out_valid && cnt < 400) begin
            @(negedge clk);
            cnt++;
            W = rand61();
        end
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("latency", 64'(cnt), 64'(e.lat));
        chk_result(e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            W = rand61();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk_result(e);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("retire_valid", 64'(out_valid), 64'd0);
        chk("retire_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic decode(input logic [60:0] w, input int hold);
        exp_t e;
        e = model({3'b000, w});
        start(w);
        finish(e, hold);
    endtask

    initial begin
        logic [63:0] x, w64;
        int          mode;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_idle_zero();

        decode(61'd655, 0);
        decode(61'd663, 0);
        decode(61'd130, 0);
        decode(61'd1, 0);
        decode(61'd745, 0);
        decode(61'd125, 0);
        decode({61{1'b1}}, 0);
        decode(61'd655, 10);
        decode(61'd0, 1);

        // Abort mid-way through the second division.
        start(61'd663);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero();
        decode(61'd655, 0);

        for (int i = 0; i < 30; i++) begin
            mode = int'($urandom_range(0, 3));
            x = 64'(rand61()) % (WLIM / A64);
            w64 = x * A64;
            if (mode == 1) begin
                if ($urandom_range(0, 1) == 1) w64 = w64 + (64'd1 << $urandom_range(0, LOC_MAX));
                else w64 = w64 - (64'd1 << $urandom_range(0, LOC_MAX));
            end else if (mode == 2) begin
                w64 = 64'(rand61());
            end else if (mode == 3) begin
                w64 = 64'($urandom_range(0, 2000));
            end else begin
                w64 = w64;
            end
            decode(w64[60:0], int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
